poly_eval_device: RTL
=====================

# poly_eval_device

Memory-mapped polynomial evaluator on the CPU data bus, in the same address window as the existing accelerator device. Software loads x, a degree and up to MAX_DEG+1 coefficients, then writes a start command. The block evaluates c[deg]·x^deg + … + c[1]·x + c[0] by Horner's rule, one multiply-accumulate per clock. Busy/done status and the result are readable over the bus.

## Interface
Parameters:
- DATA_W, 32: datapath, register and result width.
- MAX_DEG, 8: highest supported degree; legal range 1..15.
- BASE_ADDR, 32'h40000000: base of the register window.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- MemRead, input, 1: bus read enable.
- MemWrite, input, 1: bus write enable; write is sampled at the rising edge of clk.
- MemBus_Address, input, 32: byte address of the access.
- MemBus_Write_Data, input, 32: write data; the low DATA_W bits are used.
- Device_Read_Data, output, DATA_W: read data, combinational from the address.

Register map (offsets from BASE_ADDR):
- 0x00 X: rw.
- 0x04 DEG: rw, 4 bits.
- 0x08 CTRL: wo. Writing with bit0=1 issues start. Reads return 0.
- 0x0C STATUS: ro. bit0 = busy, bit1 = done. Any write clears done.
- 0x10 ANS: ro, last result.
- 0x20+4·i COEF[i]: rw, for i = 0..MAX_DEG.

## Operation
- Reset values: X, DEG, all COEF, ANS, accumulator, index, busy and done are 0. Device_Read_Data is 0.
- **Write to DEG:** a value greater than MAX_DEG is stored as MAX_DEG.
- **Read decode:** when MemRead=1 and the address matches a mapped register, Device_Read_Data returns that register. For an unmapped address, or when MemRead=0, it returns 0.
- **States:** IDLE and RUN. busy=1 exactly while in RUN.
- **Start in IDLE:** an accepted start clears done.
  - DEG=0: ANS←COEF[0] and done←1 at the same edge; the block stays in IDLE.
  - DEG>0: acc←COEF[DEG], idx←DEG, go to RUN.
- **Each RUN edge:**
  - t = acc·X + COEF[idx−1], truncated to DATA_W (mod 2^DATA_W, unsigned).
  - acc←t, idx←idx−1.
  - When idx==1: ANS←t, done←1, return to IDLE.
- **While busy:**
  - Writes to X, DEG, COEF and CTRL are ignored, so operands are stable for the whole evaluation.
  - ANS keeps the previous result until completion.
- **Simultaneous events:** completion and a STATUS write at the same edge leave done=1; completion wins.
- **Reset mid-RUN:** the operation is aborted, all state returns to reset values, and no partial result is written to ANS.
- ANS and done remain valid until the next accepted start, or until reset.

## Timing
- Start write edge = E0. For DEG=d>0, busy=1 from E0 through Ed, and ANS/done update at edge Ed. Latency is d cycles; the earliest back-to-back start is at edge Ed+1.
- For DEG=0, the result is visible after E0 (0 cycles busy).
- Register writes become visible on reads in the cycle after the write edge.
- Device_Read_Data has no register stage. A read in the same cycle as a write returns the old value.

## Test plan
- Reset, then read all mapped registers and one unmapped address (0x14) → all return 0. Assert reset during RUN → busy=0 and ANS=0 immediately.
- COEF[0..4]=1, DEG=4, X=2, start → busy for 4 cycles, then ANS=31 and STATUS=0b10. Repeat with X=3 → ANS=121.
- DEG=0, COEF[0]=0x1234, start → ANS=0x1234 and done=1 at the start edge; busy never asserted.
- COEF[1]=0xFFFFFFFF, COEF[0]=2, DEG=1, X=2 → ANS=0x00000000 (wrap, mod 2^32). Write DEG=12 with MAX_DEG=8 → reading DEG returns 8.
- During RUN, write X=9, COEF[0]=7 and a second start → result matches the original operands, and reads of X/COEF[0] show the unchanged values.
- Write STATUS at the same edge completion occurs → done=1. A later STATUS write clears it → STATUS=0b00, and ANS is unchanged.

Source files
------------

// File: rtl/poly_eval_device.sv
// Memory-mapped Horner polynomial evaluator: software loads X, DEG and COEF[],
// writes CTRL.start, and the block does one multiply-accumulate per clock.
module poly_eval_device #(
  parameter int          DATA_W    = 32,
  parameter int          MAX_DEG   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       MemBus_Address,
  input  logic [31:0]       MemBus_Write_Data,
  output logic [DATA_W-1:0] Device_Read_Data
);

  localparam int NC = MAX_DEG + 1;

  // Bus handshake: there is no valid/ready pair. A write is taken at the rising
  // edge whenever MemWrite=1; a read is answered combinationally while MemRead=1.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              busy;
  logic [DATA_W-1:0] x_q, acc_q, ans_q;
  logic [3:0]        deg_q, idx_q;
  logic [DATA_W-1:0] coef_q [NC];
  logic              done_q;

  logic [31:0]       off;
  logic              hit_x, hit_deg, hit_ctrl, hit_status, hit_ans;
  logic [NC-1:0]     coef_hit;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        deg_wr;
  logic              cfg_we, start, last;
  logic [3:0]        idx_m1;
  logic [DATA_W-1:0] coef_top, coef_nxt, t;

  // Addresses below BASE_ADDR wrap to huge offsets and therefore never match.
  assign off        = MemBus_Address - BASE_ADDR;
  assign hit_x      = (off == 32'h00);
  assign hit_deg    = (off == 32'h04);
  assign hit_ctrl   = (off == 32'h08);
  assign hit_status = (off == 32'h0C);
  assign hit_ans    = (off == 32'h10);

  always_comb begin
    coef_hit = '0;
    for (int i = 0; i < NC; i++) begin
      coef_hit[i] = (off == 32'h20 + 32'(4 * i));
    end
  end

  assign wdata  = MemBus_Write_Data[DATA_W-1:0];
  assign deg_wr = (wdata > DATA_W'(MAX_DEG)) ? 4'(MAX_DEG) : wdata[3:0];

  // Operand registers are frozen while busy so the evaluation sees stable inputs.
  assign cfg_we = MemWrite && !busy;
  assign start  = MemWrite && hit_ctrl && MemBus_Write_Data[0] && (state == IDLE);
  assign last   = (state == RUN) && (idx_q == 4'd1);
  assign idx_m1 = idx_q - 4'd1;

  always_comb begin
    coef_top = '0;
    coef_nxt = '0;
    for (int i = 0; i < NC; i++) begin
      if (deg_q == 4'(i))  coef_top = coef_q[i];
      if (idx_m1 == 4'(i)) coef_nxt = coef_q[i];
    end
  end

  assign t = acc_q * x_q + coef_nxt;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (deg_q != 4'd0)) state_nxt = RUN;
      RUN:     if (idx_q == 4'd1)            state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == RUN);
  end

  // Datapath and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      deg_q  <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      ans_q  <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < NC; i++) coef_q[i] <= '0;
    end else begin
      if (cfg_we && hit_x)   x_q   <= wdata;
      if (cfg_we && hit_deg) deg_q <= deg_wr;
      for (int i = 0; i < NC; i++) begin
        if (cfg_we && coef_hit[i]) coef_q[i] <= wdata;
      end

      // STATUS clear is written first so a same-edge completion overrides it.
      if (MemWrite && hit_status) done_q <= 1'b0;

      if (start) begin
        done_q <= 1'b0;
        if (deg_q == 4'd0) begin
          ans_q  <= coef_q[0];
          done_q <= 1'b1;
        end else begin
          acc_q <= coef_top;
          idx_q <= deg_q;
        end
      end

      if (state == RUN) begin
        acc_q <= t;
        idx_q <= idx_m1;
      end

      if (last) begin
        ans_q  <= t;
        done_q <= 1'b1;
      end
    end
  end

  // Read mux: combinational, zero for unmapped addresses or when not reading.
  always_comb begin
    Device_Read_Data = '0;
    if (MemRead) begin
      if (hit_x)      Device_Read_Data = x_q;
      if (hit_deg)    Device_Read_Data = DATA_W'(deg_q);
      if (hit_status) Device_Read_Data = DATA_W'({done_q, busy});
      if (hit_ans)    Device_Read_Data = ans_q;
      for (int i = 0; i < NC; i++) begin
        if (coef_hit[i]) Device_Read_Data = coef_q[i];
      end
    end
  end

endmodule
